// File: rtl/alu_seq_pkg.sv
// Shared op-codes, FSM state encoding and default settle count for the
// ALU sequencer and its helpers.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_CMP  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        DRIVE   = 2'b01,
        CAPTURE = 2'b10,
        DONE    = 2'b11
    } state_e;

    localparam int DEFAULT_SETTLE_CYCLES = 2;

endpackage

// File: rtl/alu_sequencer_settle_counter.sv
// Loadable down-counter that times how long the ALU outputs are allowed to
// settle before the result bus is sampled.
module settle_counter #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          load,
    input  logic          dec,
    input  logic [CW-1:0] load_value,
    output logic          zero
);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Start/Done sequencer for an external combinational add/subtract unit:
// drives operands, waits for the result to settle, then captures it.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
    parameter int WIDTH         = 4
) (
    input  logic             CLK,
    input  logic             nReset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] Operand,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Acc,
    output logic             CarryFlag,
    output logic             ZeroFlag,
    output logic [WIDTH-1:0] AluA,
    output logic [WIDTH-1:0] AluB,
    output logic             AluSub,
    output logic             AluEnable,
    input  logic [WIDTH-1:0] AluResult,
    input  logic             AluCarry
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    state_e           state_reg, state_next;
    op_e              op_reg;
    op_e              op_in;
    logic [WIDTH-1:0] operand_reg;
    logic [WIDTH-1:0] acc_reg;
    logic             carry_reg;
    logic             zero_reg;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;

    assign op_in = op_e'(Op);

    settle_counter #(
        .CW(CW)
    ) u_settle (
        .clk       (CLK),
        .nreset    (nReset),
        .load      (cnt_load),
        .dec       (cnt_dec),
        .load_value(CW'(SETTLE_CYCLES - 1)),
        .zero      (cnt_zero)
    );

    always_comb begin
        state_next = state_reg;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (Start) begin
                    if (op_in == OP_LOAD) begin
                        state_next = DONE;
                    end else begin
                        state_next = DRIVE;
                        cnt_load   = 1'b1;
                    end
                end
            end
            DRIVE: begin
                if (cnt_zero) begin
                    state_next = CAPTURE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            CAPTURE: state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nReset) begin
            state_reg   <= IDLE;
            op_reg      <= OP_LOAD;
            operand_reg <= '0;
            acc_reg     <= '0;
            carry_reg   <= 1'b0;
            zero_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if ((state_reg == IDLE) && Start) begin
                op_reg      <= op_in;
                operand_reg <= Operand;
                if (op_in == OP_LOAD) begin
                    acc_reg  <= Operand;
                    zero_reg <= (Operand == '0);
                end
            end
            // Result bus is only valid here, while the drivers are enabled.
            if (state_reg == CAPTURE) begin
                carry_reg <= AluCarry;
                zero_reg  <= (AluResult == '0);
                if (op_reg != OP_CMP) begin
                    acc_reg <= AluResult;
                end
            end
        end
    end

    assign Busy      = (state_reg == DRIVE) || (state_reg == CAPTURE);
    assign AluEnable = Busy;
    assign Done      = (state_reg == DONE);
    assign Acc       = acc_reg;
    assign CarryFlag = carry_reg;
    assign ZeroFlag  = zero_reg;
    assign AluA      = acc_reg;
    assign AluB      = operand_reg;
    assign AluSub    = (op_reg == OP_SUB) || (op_reg == OP_CMP);

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural add/subtract unit on a tri-state bus,
// vector table, hand-written corner sequences and a randomized model check.
module tb_alu_sequencer;

    localparam int SETTLE = 2;
    localparam int W      = 4;

    logic         CLK = 1'b0;
    logic         nReset;
    logic         Start;
    logic [1:0]   Op;
    logic [W-1:0] Operand;
    logic         Busy, Done, CarryFlag, ZeroFlag, AluSub, AluEnable;
    logic [W-1:0] Acc, AluA, AluB;
    wire  [W-1:0] AluResult;
    logic         AluCarry;
    logic [W:0]   alu_sum;

    int checks   = 0;
    int failures = 0;

    logic [3:0] acc_m;
    logic       c_m, z_m;

    always #5 CLK = ~CLK;

    assign alu_sum   = {1'b0, AluA} + {1'b0, (AluSub ? ~AluB : AluB)} + {4'b0, AluSub};
    assign AluResult = AluEnable ? alu_sum[W-1:0] : {W{1'bz}};
    assign AluCarry  = alu_sum[W];

    alu_sequencer #(.SETTLE_CYCLES(SETTLE), .WIDTH(W)) dut (
        .CLK(CLK), .nReset(nReset), .Start(Start), .Op(Op), .Operand(Operand),
        .Busy(Busy), .Done(Done), .Acc(Acc), .CarryFlag(CarryFlag),
        .ZeroFlag(ZeroFlag), .AluA(AluA), .AluB(AluB), .AluSub(AluSub),
        .AluEnable(AluEnable), .AluResult(AluResult), .AluCarry(AluCarry)
    );

    typedef struct {
        logic [1:0] op;
        logic [3:0] val;
        logic [3:0] exp_acc;
        logic       exp_c;
        logic       exp_z;
        int         exp_lat;
        int         exp_en;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Reference: arithmetic straight from the op definitions.
    task automatic model(input logic [1:0] op, input logic [3:0] v);
        int a, b;
        a = int'(acc_m);
        b = int'(v);
        case (op)
            2'd0: begin acc_m = v; z_m = (b == 0); end
            2'd1: begin c_m = (a + b) > 15; acc_m = 4'((a + b) % 16); z_m = (acc_m == 0); end
            2'd2: begin c_m = (a >= b); acc_m = 4'((a - b + 16) % 16); z_m = (acc_m == 0); end
            default: begin c_m = (a >= b); z_m = (a == b); end
        endcase
    endtask

    // Called #1 after an edge with the DUT in IDLE; returns in the Done cycle.
    task automatic run_op(input logic [1:0] op, input logic [3:0] v,
                          output int lat, output int en_cnt, output int bad_drive);
        Start = 1'b1; Op = op; Operand = v;
        step();
        Start = 1'b0;
        lat = 1; en_cnt = 0; bad_drive = 0;
        while (!Done && lat < 20) begin
            if (AluEnable) begin
                en_cnt++;
                if (AluB != v || AluSub != (op != 2'd1)) bad_drive++;
                if (!Busy) bad_drive++;
            end
            step();
            lat++;
        end
        $display("op=%0d operand=%0d lat=%0d en=%0d acc=%0d c=%0d z=%0d",
                 op, v, lat, en_cnt, Acc, CarryFlag, ZeroFlag);
    endtask

    initial begin
        int lat, en, bad, dones;
        logic [1:0] rop;
        logic [3:0] rv;

        vecs[0] = '{2'd0, 4'd5,  4'd5,  1'b0, 1'b0, 1, 0};
        vecs[1] = '{2'd1, 4'd3,  4'd8,  1'b0, 1'b0, SETTLE + 2, SETTLE + 1};
        vecs[2] = '{2'd1, 4'd9,  4'd1,  1'b1, 1'b0, SETTLE + 2, SETTLE + 1};
        vecs[3] = '{2'd2, 4'd1,  4'd0,  1'b1, 1'b1, SETTLE + 2, SETTLE + 1};
        vecs[4] = '{2'd0, 4'd1,  4'd1,  1'b1, 1'b0, 1, 0};
        vecs[5] = '{2'd2, 4'd3,  4'd14, 1'b0, 1'b0, SETTLE + 2, SETTLE + 1};
        vecs[6] = '{2'd3, 4'd14, 4'd14, 1'b1, 1'b1, SETTLE + 2, SETTLE + 1};

        nReset = 1'b0; Start = 1'b0; Op = 2'd0; Operand = 4'd0;
        step(); step();
        nReset = 1'b1;
        acc_m = 4'd0; c_m = 1'b0; z_m = 1'b0;
        check("reset_busy", int'(Busy), 0);
        check("reset_done", int'(Done), 0);
        check("reset_en", int'(AluEnable), 0);
        check("reset_acc", int'(Acc), 0);
        check("reset_flags", int'({CarryFlag, ZeroFlag, AluSub}), 0);
        check("reset_alub", int'(AluB), 0);

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].op, vecs[i].val, lat, en, bad);
            model(vecs[i].op, vecs[i].val);
            check("vec_lat", lat, vecs[i].exp_lat);
            check("vec_en_cycles", en, vecs[i].exp_en);
            check("vec_drive", bad, 0);
            check("vec_acc", int'(Acc), int'(vecs[i].exp_acc));
            check("vec_carry", int'(CarryFlag), int'(vecs[i].exp_c));
            check("vec_zero", int'(ZeroFlag), int'(vecs[i].exp_z));
            step();
            check("vec_done_single", int'(Done), 0);
        end

        // Start during DONE must be ignored.
        run_op(2'd1, 4'd1, lat, en, bad);
        model(2'd1, 4'd1);
        Start = 1'b1; Op = 2'd0; Operand = 4'd3;
        step();
        Start = 1'b0;
        check("done_start_busy", int'(Busy), 0);
        step();
        check("done_start_nodone", int'(Done), 0);
        check("done_start_acc", int'(Acc), int'(acc_m));

        // Start pulsed during DRIVE is ignored.
        run_op(2'd0, 4'd4, lat, en, bad);
        step();
        Start = 1'b1; Op = 2'd1; Operand = 4'd2;
        step();
        Operand = 4'd7;
        step();
        Start = 1'b0;
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            if (Done) dones++;
            step();
        end
        check("busy_start_dones", dones, 1);
        check("busy_start_acc", int'(Acc), 6);
        acc_m = 4'd6; c_m = 1'b0; z_m = 1'b0;

        // Reset asserted during CAPTURE aborts the operation.
        Start = 1'b1; Op = 2'd1; Operand = 4'd5;
        step();
        Start = 1'b0;
        step();
        step();
        check("capture_en", int'(AluEnable), 1);
        nReset = 1'b0;
        step();
        nReset = 1'b1;
        check("abort_en", int'(AluEnable), 0);
        check("abort_busy", int'(Busy), 0);
        check("abort_acc", int'(Acc), 0);
        check("abort_done", int'(Done), 0);
        dones = 0;
        for (int k = 0; k < 5; k++) begin
            if (Done) dones++;
            step();
        end
        check("abort_no_done", dones, 0);
        acc_m = 4'd0; c_m = 1'b0; z_m = 1'b0;
        run_op(2'd0, 4'd9, lat, en, bad);
        model(2'd0, 4'd9);
        check("post_abort_lat", lat, 1);
        check("post_abort_acc", int'(Acc), 9);
        step();

        for (int r = 0; r < 150; r++) begin
            rop = 2'($urandom_range(0, 3));
            rv  = 4'($urandom_range(0, 15));
            run_op(rop, rv, lat, en, bad);
            model(rop, rv);
            check("rnd_lat", lat, (rop == 2'd0) ? 1 : SETTLE + 2);
            check("rnd_drive", bad, 0);
            check("rnd_acc", int'(Acc), int'(acc_m));
            check("rnd_carry", int'(CarryFlag), int'(c_m));
            check("rnd_zero", int'(ZeroFlag), int'(z_m));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
